// File: rtl/vera_linebuf_pkg.sv
// Shared constants, entry layout and index helper for the sprite line buffer.
package vera_linebuf_pkg;

  localparam int unsigned ACTIVE_WIDTH = 640;
  localparam int unsigned IDX_W        = 10;
  localparam int unsigned DATA_W       = 16;

  localparam int unsigned COLL_LSB  = 12;
  localparam int unsigned Z_LSB     = 8;
  localparam int unsigned COLOR_LSB = 0;

  typedef struct packed {
    logic [3:0] collision;
    logic [1:0] rsvd;
    logic [1:0] z;
    logic [7:0] color;
  } linebuf_entry_t;

  // True when an index addresses a stored (on-screen) entry.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return idx < IDX_W'(ACTIVE_WIDTH);
  endfunction

endpackage

// File: rtl/sprite_line_buffer_if.sv
// Renderer/composer bus of the sprite line buffer.
interface sprite_line_buffer_if;
  import vera_linebuf_pkg::*;

  logic                 line_render_start;
  logic [IDX_W-1:0]     spr_rdidx;
  linebuf_entry_t       spr_rddata;
  logic [IDX_W-1:0]     spr_wridx;
  linebuf_entry_t       spr_wrdata;
  logic                 spr_wren;
  logic [IDX_W-1:0]     comp_rdidx;
  linebuf_entry_t       comp_rddata;
  logic                 render_bank;

  modport master (
    output line_render_start, spr_rdidx, spr_wridx, spr_wrdata, spr_wren, comp_rdidx,
    input  spr_rddata, comp_rddata, render_bank
  );

  modport slave (
    input  line_render_start, spr_rdidx, spr_wridx, spr_wrdata, spr_wren, comp_rdidx,
    output spr_rddata, comp_rddata, render_bank
  );

endinterface

// File: rtl/linebuf_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module linebuf_sdp_ram
  import vera_linebuf_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [ACTIVE_WIDTH];

  // Contents are not reset; valid bits in the parent gate every read.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite line buffer: renderer RMWs one bank, composer reads the other.
module sprite_line_buffer
  import vera_linebuf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_line_buffer_if.slave  bus
);

  logic                    bank_sel_q, bank_sel_d;
  logic [ACTIVE_WIDTH-1:0] vld0_q, vld0_d, vld1_q, vld1_d;

  logic                    wr_ok;
  logic                    spr_hit_d, spr_hit_q, spr_bank_q;
  logic                    spr_byp_d, spr_byp_q;
  logic [DATA_W-1:0]       spr_bypdata_q;
  logic                    comp_hit_d, comp_hit_q, comp_bank_q;
  logic [DATA_W-1:0]       rd0, rd1;
  logic [IDX_W-1:0]        raddr0, raddr1;

  assign wr_ok  = bus.spr_wren && idx_in_range(bus.spr_wridx);
  assign raddr0 = bank_sel_q ? bus.comp_rdidx : bus.spr_rdidx;
  assign raddr1 = bank_sel_q ? bus.spr_rdidx  : bus.comp_rdidx;

  linebuf_sdp_ram u_bank0 (
    .clk     (clk),
    .we_i    (wr_ok && !bank_sel_q),
    .waddr_i (bus.spr_wridx),
    .wdata_i (bus.spr_wrdata),
    .raddr_i (raddr0),
    .rdata_o (rd0)
  );

  linebuf_sdp_ram u_bank1 (
    .clk     (clk),
    .we_i    (wr_ok && bank_sel_q),
    .waddr_i (bus.spr_wridx),
    .wdata_i (bus.spr_wrdata),
    .raddr_i (raddr1),
    .rdata_o (rd1)
  );

  // Write and flash-clear always hit different banks, so no ordering conflict.
  always_comb begin
    bank_sel_d = bank_sel_q;
    vld0_d     = vld0_q;
    vld1_d     = vld1_q;
    if (wr_ok) begin
      if (bank_sel_q) vld1_d[bus.spr_wridx] = 1'b1;
      else            vld0_d[bus.spr_wridx] = 1'b1;
    end
    if (bus.line_render_start) begin
      bank_sel_d = ~bank_sel_q;
      if (bank_sel_q) vld0_d = '0;
      else            vld1_d = '0;
    end
  end

  always_comb begin
    spr_hit_d  = 1'b0;
    comp_hit_d = 1'b0;
    spr_byp_d  = wr_ok && (bus.spr_wridx == bus.spr_rdidx);
    if (idx_in_range(bus.spr_rdidx))
      spr_hit_d = bank_sel_q ? vld1_q[bus.spr_rdidx] : vld0_q[bus.spr_rdidx];
    if (idx_in_range(bus.comp_rdidx))
      comp_hit_d = bank_sel_q ? vld0_q[bus.comp_rdidx] : vld1_q[bus.comp_rdidx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_q    <= 1'b0;
      vld0_q        <= '0;
      vld1_q        <= '0;
      spr_hit_q     <= 1'b0;
      spr_bank_q    <= 1'b0;
      spr_byp_q     <= 1'b0;
      spr_bypdata_q <= '0;
      comp_hit_q    <= 1'b0;
      comp_bank_q   <= 1'b0;
    end else begin
      bank_sel_q    <= bank_sel_d;
      vld0_q        <= vld0_d;
      vld1_q        <= vld1_d;
      spr_hit_q     <= spr_hit_d;
      spr_bank_q    <= bank_sel_q;
      spr_byp_q     <= spr_byp_d;
      spr_bypdata_q <= bus.spr_wrdata;
      comp_hit_q    <= comp_hit_d;
      comp_bank_q   <= ~bank_sel_q;
    end
  end

  // Bank choice is the one captured when the index was presented.
  assign bus.spr_rddata  = spr_byp_q ? linebuf_entry_t'(spr_bypdata_q)
                         : spr_hit_q ? linebuf_entry_t'(spr_bank_q ? rd1 : rd0)
                         : '0;
  assign bus.comp_rddata = comp_hit_q ? linebuf_entry_t'(comp_bank_q ? rd1 : rd0) : '0;
  assign bus.render_bank = bank_sel_q;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Directed bench for sprite_line_buffer with hand-computed expectations.
module tb_sprite_line_buffer;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  sprite_line_buffer_if bus ();

  sprite_line_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n                 = 1'b0;
    bus.line_render_start = 1'b0;
    bus.spr_rdidx         = '0;
    bus.spr_wridx         = '0;
    bus.spr_wrdata        = '0;
    bus.spr_wren          = 1'b0;
    bus.comp_rdidx        = '0;
    tick(); tick();
    rst_n = 1'b1;

    // empty buffer after reset
    chk("rst_bank", 16'(bus.render_bank), 16'h0);
    bus.spr_rdidx = 10'd0;   bus.comp_rdidx = 10'd0;   tick();
    chk("rst_spr0", bus.spr_rddata, 16'h0);   chk("rst_comp0", bus.comp_rddata, 16'h0);
    bus.spr_rdidx = 10'd639; bus.comp_rdidx = 10'd639; tick();
    chk("rst_spr639", bus.spr_rddata, 16'h0); chk("rst_comp639", bus.comp_rddata, 16'h0);
    bus.spr_rdidx = 10'd700; bus.comp_rdidx = 10'd700; tick();
    chk("rst_spr700", bus.spr_rddata, 16'h0); chk("rst_comp700", bus.comp_rddata, 16'h0);

    // write then swap
    bus.spr_rdidx = 10'd0;
    bus.spr_wren = 1'b1; bus.spr_wridx = 10'd100; bus.spr_wrdata = 16'h3A55; tick();
    bus.spr_wren = 1'b0; bus.spr_rdidx = 10'd100; tick();
    chk("wr_rd100", bus.spr_rddata, 16'h3A55);
    bus.line_render_start = 1'b1; tick();
    bus.line_render_start = 1'b0;
    chk("swap1_bank", 16'(bus.render_bank), 16'h1);
    bus.comp_rdidx = 10'd100; bus.spr_rdidx = 10'd100; tick();
    chk("swap1_comp100", bus.comp_rddata, 16'h3A55);
    chk("swap1_spr100", bus.spr_rddata, 16'h0);

    // write-first bypass
    bus.spr_wren = 1'b1; bus.spr_wridx = 10'd200; bus.spr_wrdata = 16'h1234; bus.spr_rdidx = 10'd200; tick();
    chk("byp200", bus.spr_rddata, 16'h1234);
    bus.spr_wren = 1'b0; tick();
    chk("stored200", bus.spr_rddata, 16'h1234);

    // off-screen write dropped
    bus.spr_wren = 1'b1; bus.spr_wridx = 10'd700; bus.spr_wrdata = 16'hFFFF; bus.spr_rdidx = 10'd700; tick();
    chk("oob_byp700", bus.spr_rddata, 16'h0);
    bus.spr_wren = 1'b0; bus.comp_rdidx = 10'd700; tick();
    chk("oob_spr700", bus.spr_rddata, 16'h0);
    chk("oob_comp700", bus.comp_rddata, 16'h0);

    // wrap from 1023 into 0
    bus.spr_rdidx = 10'd1;
    bus.spr_wren = 1'b1; bus.spr_wridx = 10'd1023; bus.spr_wrdata = 16'hAAAA; tick();
    bus.spr_wridx = 10'd0; bus.spr_wrdata = 16'h0BBB; tick();
    bus.spr_wren = 1'b0; bus.spr_rdidx = 10'd0; tick();
    chk("wrap_rd0", bus.spr_rddata, 16'h0BBB);
    bus.spr_rdidx = 10'd1023; tick();
    chk("wrap_rd1023", bus.spr_rddata, 16'h0);

    // two swaps: line A writes 5, line B writes 6
    bus.spr_wren = 1'b1; bus.spr_wridx = 10'd5; bus.spr_wrdata = 16'h0105; tick();
    bus.spr_wren = 1'b0; bus.line_render_start = 1'b1; tick();
    bus.line_render_start = 1'b0;
    bus.spr_wren = 1'b1; bus.spr_wridx = 10'd6; bus.spr_wrdata = 16'h0206; tick();
    bus.spr_wren = 1'b0; bus.line_render_start = 1'b1; tick();
    bus.line_render_start = 1'b0;
    chk("swap2_bank", 16'(bus.render_bank), 16'h1);
    bus.comp_rdidx = 10'd6; bus.spr_rdidx = 10'd5; tick();
    chk("swap2_comp6", bus.comp_rddata, 16'h0206);
    chk("swap2_spr5", bus.spr_rddata, 16'h0);
    bus.comp_rdidx = 10'd5; tick();
    chk("swap2_comp5", bus.comp_rddata, 16'h0);

    // write in the same cycle as the swap
    bus.spr_wren = 1'b1; bus.spr_wridx = 10'd10; bus.spr_wrdata = 16'h0155; bus.line_render_start = 1'b1; tick();
    bus.spr_wren = 1'b0; bus.line_render_start = 1'b0; bus.comp_rdidx = 10'd10; tick();
    chk("simul_comp10", bus.comp_rddata, 16'h0155);
    chk("simul_bank", 16'(bus.render_bank), 16'h0);

    // renderer read in the same cycle as the swap uses the old bank
    bus.spr_wren = 1'b1; bus.spr_wridx = 10'd20; bus.spr_wrdata = 16'h0777; tick();
    bus.spr_wren = 1'b0; bus.spr_rdidx = 10'd20; bus.line_render_start = 1'b1; tick();
    bus.line_render_start = 1'b0;
    chk("rdswap_spr20", bus.spr_rddata, 16'h0777);
    bus.comp_rdidx = 10'd20; tick();
    chk("postswap_spr20", bus.spr_rddata, 16'h0);
    chk("postswap_comp20", bus.comp_rddata, 16'h0777);

    // asynchronous reset mid-cycle
    bus.spr_wren = 1'b1; bus.spr_wridx = 10'd30; bus.spr_wrdata = 16'h0999; bus.spr_rdidx = 10'd30; tick();
    chk("pre_rst_spr", bus.spr_rddata, 16'h0999);
    chk("pre_rst_comp", bus.comp_rddata, 16'h0777);
    bus.spr_wren = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_spr", bus.spr_rddata, 16'h0);
    chk("arst_comp", bus.comp_rddata, 16'h0);
    chk("arst_bank", 16'(bus.render_bank), 16'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_spr30", bus.spr_rddata, 16'h0);
    chk("post_rst_comp20", bus.comp_rddata, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sprite_line_buffer.md
# sprite_line_buffer

Double-buffered sprite line buffer between `sprite_renderer` and the composer. During line N, the renderer read-modify-writes one bank while the composer reads the other bank, which holds the finished line N-1. The bank roles swap on `line_render_start`. A per-entry valid bit clears the newly assigned render bank in a single cycle, so no clear sweep is needed.

## Interface
Parameters:
- `ACTIVE_WIDTH`, 640: number of stored entries per bank. Indices at or above this value are off-screen.
- `IDX_W`, 10: pixel index width.
- `DATA_W`, 16: entry width, laid out as {collision[3:0], 2'b0, z[1:0], color[7:0]}.

Ports:
- `clk`  in  1: single clock. Everything is rising-edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `line_render_start`  in  1: one-cycle pulse; swaps the bank roles.
- `spr_rdidx`  in  `IDX_W`: renderer read index.
- `spr_rddata`  out  `DATA_W`: renderer read data, one cycle after the index is presented.
- `spr_wridx`  in  `IDX_W`: renderer write index.
- `spr_wrdata`  in  `DATA_W`: renderer write data.
- `spr_wren`  in  1: renderer write enable.
- `comp_rdidx`  in  `IDX_W`: composer read index; presented every cycle, random access.
- `comp_rddata`  out  `DATA_W`: composer read data, one cycle after the index is presented.
- `render_bank`  out  1: current render bank. The display bank is `~render_bank`.

## Operation
- **State:** `bank_sel` register (drives `render_bank`), two RAM banks of `ACTIVE_WIDTH`×`DATA_W`, and two `ACTIVE_WIDTH`-bit valid vectors `vld0`/`vld1`.
- **Reset values:** `bank_sel`=0, all valid bits=0, `spr_rddata`=0, `comp_rddata`=0. RAM contents are don't-care because valid bits gate every read.
- **Renderer write:** when `spr_wren`=1 and `spr_wridx` < `ACTIVE_WIDTH`:
  - RAM[`bank_sel`][`spr_wridx`] ← `spr_wrdata`
  - the matching valid bit ← 1.
  - Writes with `spr_wridx` ≥ `ACTIVE_WIDTH` are dropped silently.
- **Index wrap:** indices are plain `IDX_W`-bit values. A sprite running from 1023 into 0 lands at entries 0.. as normal writes.
- **Renderer read:**
  - `spr_rddata` ← (idx < `ACTIVE_WIDTH` && valid) ? RAM : 0.
  - The bank is the one selected at the cycle the index is presented.
- **Renderer write-first bypass:** if `spr_wren`=1, `spr_wridx`==`spr_rdidx`, and the index is < `ACTIVE_WIDTH`, the next `spr_rddata` = `spr_wrdata`.
- **Composer read:**
  - `comp_rddata` ← (idx < `ACTIVE_WIDTH` && valid in bank `~bank_sel`) ? RAM : 0.
  - Reads are non-destructive; repeated or skipped indices are legal (h-scaling).
- **Swap on `line_render_start`:**
  - `bank_sel` toggles.
  - The valid vector of the new render bank (the old display bank) is cleared to all-zero on the same edge.
- **Write coinciding with `line_render_start`:** the write goes to the old render bank, using `bank_sel` before the toggle. It is not lost, and the composer sees it during the next line.
- **Read coinciding with `line_render_start`:** the read returns data from the pre-swap bank assignment.
- **Valid-bit write and clear on the same entry in one cycle:** impossible, because write and clear always target different banks.
- **Reset mid-line:** all state returns to reset values immediately; the buffer reads as empty.

## Timing
- Read latency on both read paths: exactly 1 cycle, with registered outputs.
- Write-to-read latency: a renderer write at cycle t is visible to a renderer read presented at cycle t (via the bypass) or later.
- Renderer-write-to-composer visibility: a pixel written during line N is readable by the composer from the first cycle after the `line_render_start` edge that ends line N, and until the next swap.
- No stalls and no handshake; all paths are single-cycle throughput.

## Structure
- **Shared package `vera_linebuf_pkg`:** `ACTIVE_WIDTH`, `IDX_W`, `DATA_W`, the entry field offsets (COLL_LSB=12, Z_LSB=8, COLOR_LSB=0), and the typedef `linebuf_entry_t`.
- **Sub-module `linebuf_sdp_ram`:** simple dual-port RAM, one write port and one registered read port, instantiated twice.
  - Write port: driven by the renderer, gated to the render bank.
  - Read address mux: `spr_rdidx` when the bank is the render bank, `comp_rdidx` otherwise.
- **Top level holds:** `bank_sel`, the valid vectors, the bypass compare, and the output muxes.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle → outputs 0 asynchronously, `render_bank`=0. After release, reads at indices 0, 639 and 700 return 0 on both ports.
- **Write then swap:**
  - Write 0x3A55 at index 100, then read index 100 on the renderer port → 0x3A55.
  - Pulse `line_render_start` → `render_bank`=1.
  - Composer read at 100 → 0x3A55; renderer read at 100 → 0.
- **Bypass:** `spr_rdidx`=`spr_wridx`=200 with `spr_wren`=1 and data 0x1234 → `spr_rddata`=0x1234 on the next cycle.
- **Bounds:**
  - Write 0xFFFF at index 700 → dropped; read at 700 → 0.
  - Write at 1023, then at 0 → only entry 0 holds data.
- **Two swaps:** line A writes index 5; swap; line B writes index 6; swap.
  - Composer reads 6 → data; composer reads 5 → 0.
  - Renderer reads 5 → 0 (flash clear).
- **Simultaneous write and swap:** write 0x0155 at index 10 in the same cycle as `line_render_start` → the composer reads 0x0155 at index 10 on the following cycle.
